supply_ramp_ctrl: RTL

SUPPLY_RAMP_CTRL -- requirements
Module: supply_ramp_ctrl

---
 rtl/supply_ramp_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/supply_ramp_ctrl.sv
// Supply ramp sequencer: steps a regulator DAC up from zero, supervises the measured
// supply against captured thresholds and latches sticky fault flags.
module supply_ramp_ctrl #(
   parameter int W        = 8,
   parameter int STEP     = 1,
   parameter int STEP_DIV = 4,
   parameter int DEB      = 3,
   parameter int TIMEOUT  = 1000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         clear,
   input  logic [W-1:0] vdd_code,
   input  logic [W-1:0] vref_code,
   input  logic [W-1:0] vmax_code,
   input  logic [W-1:0] vbrk_code,
   output logic [W-1:0] dac_code,
   output logic         ramp_done,
   output logic         warn,
   output logic         err,
   output logic         tmo,
   output logic         cfg_bad,
   output logic         fatal,
   output logic [2:0]   state
);

   // state    | meaning
   // IDLE     | DAC at zero, waiting for start
   // RAMP     | stepping DAC up until vdd reaches vref
   // REGULATE | holding setpoint, topping up while vdd is below vref
   // FAULT    | DAC forced to zero, waiting for clear
   // SHUTDOWN | breakdown seen, absorbing until reset
   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_RAMP = 3'd1, S_REG = 3'd2, S_FAULT = 3'd3, S_SHUT = 3'd4
   } state_t;

   typedef enum logic [1:0] {C_NOM, C_WARN, C_ERR, C_BRK} cls_t;

   localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int DW = $clog2(DEB + 1);

   state_t         state_q, state_d;
   logic [W-1:0]   dac_q, dac_d;
   logic [W-1:0]   vref_q, vref_d, vmax_q, vmax_d, vbrk_q, vbrk_d;
   logic [SW-1:0]  step_cnt_q, step_cnt_d;
   logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic [DW-1:0]  deb_cnt_q, deb_cnt_d;
   logic           warn_q, warn_d, err_q, err_d, tmo_q, tmo_d;
   logic           cfg_bad_q, cfg_bad_d, fatal_q, fatal_d;

   cls_t           cls;
   logic           active, cfg_ok, step_due, err_trip, tmo_trip, brk_trip;
   logic [W:0]     dac_sum;
   logic [W-1:0]   dac_inc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         dac_q      <= '0;
         vref_q     <= '0;
         vmax_q     <= '0;
         vbrk_q     <= '0;
         step_cnt_q <= '0;
         tmo_cnt_q  <= '0;
         deb_cnt_q  <= '0;
         warn_q     <= 1'b0;
         err_q      <= 1'b0;
         tmo_q      <= 1'b0;
         cfg_bad_q  <= 1'b0;
         fatal_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         dac_q      <= dac_d;
         vref_q     <= vref_d;
         vmax_q     <= vmax_d;
         vbrk_q     <= vbrk_d;
         step_cnt_q <= step_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         deb_cnt_q  <= deb_cnt_d;
         warn_q     <= warn_d;
         err_q      <= err_d;
         tmo_q      <= tmo_d;
         cfg_bad_q  <= cfg_bad_d;
         fatal_q    <= fatal_d;
      end
   end

   always_comb begin
      if (vdd_code > vbrk_q)       cls = C_BRK;
      else if (vdd_code >= vmax_q) cls = C_ERR;
      else if (vdd_code >= vref_q) cls = C_WARN;
      else                         cls = C_NOM;
   end

   assign active   = (state_q == S_RAMP) || (state_q == S_REG);
   assign cfg_ok   = (vref_code < vmax_code) && (vmax_code <= vbrk_code);
   assign step_due = active && (step_cnt_q == '0);
   assign err_trip = active && (cls == C_ERR) && (deb_cnt_q == DW'(DEB - 1));
   assign tmo_trip = (state_q == S_RAMP) && (tmo_cnt_q == '0);
   assign brk_trip = (active || (state_q == S_FAULT)) && (cls == C_BRK);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = cfg_ok ? S_RAMP : S_FAULT;
         S_RAMP: begin
            if (brk_trip)           state_d = S_SHUT;
            else if (err_trip)      state_d = S_FAULT;
            else if (tmo_trip)      state_d = S_FAULT;
            else if (cls != C_NOM)  state_d = S_REG;
         end
         S_REG: begin
            if (brk_trip)           state_d = S_SHUT;
            else if (err_trip)      state_d = S_FAULT;
         end
         S_FAULT: begin
            if (brk_trip)           state_d = S_SHUT;
            else if (clear)         state_d = S_IDLE;
         end
         S_SHUT:                    state_d = S_SHUT;
         default:                   state_d = S_IDLE;
      endcase
   end

   // Step timer and timeout timer are down-counters reloaded on the accepted start.
   always_comb begin
      vref_d     = vref_q;
      vmax_d     = vmax_q;
      vbrk_d     = vbrk_q;
      step_cnt_d = step_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      if (state_q == S_IDLE) begin
         step_cnt_d = SW'(STEP_DIV - 1);
         tmo_cnt_d  = TW'(TIMEOUT - 1);
         if (start) begin
            vref_d = vref_code;
            vmax_d = vmax_code;
            vbrk_d = vbrk_code;
         end
      end else if (active) begin
         step_cnt_d = step_due ? SW'(STEP_DIV - 1) : step_cnt_q - SW'(1);
         if ((state_q == S_RAMP) && !tmo_trip) tmo_cnt_d = tmo_cnt_q - TW'(1);
      end
      deb_cnt_d = (active && (cls == C_ERR)) ? deb_cnt_q + DW'(1) : '0;
      warn_d    = active && (cls == C_WARN);

      dac_sum = {1'b0, dac_q} + (W+1)'(STEP);
      dac_inc = dac_sum[W] ? '1 : dac_sum[W-1:0];
      if ((state_d == S_RAMP) || (state_d == S_REG))
         dac_d = (step_due && (cls == C_NOM)) ? dac_inc : dac_q;
      else
         dac_d = '0;

      err_d     = err_q;
      tmo_d     = tmo_q;
      cfg_bad_d = cfg_bad_q;
      fatal_d   = fatal_q;
      if ((state_q == S_FAULT) && (state_d == S_IDLE)) begin
         err_d     = 1'b0;
         tmo_d     = 1'b0;
         cfg_bad_d = 1'b0;
      end
      if ((state_q == S_IDLE) && (state_d == S_FAULT)) cfg_bad_d = 1'b1;
      if (active && (state_d == S_FAULT)) begin
         if (err_trip) err_d = 1'b1;
         else          tmo_d = 1'b1;
      end
      if ((state_q != S_SHUT) && (state_d == S_SHUT)) fatal_d = 1'b1;
   end

   always_comb begin
      state     = state_q;
      dac_code  = dac_q;
      ramp_done = (state_q == S_REG);
      warn      = warn_q;
      err       = err_q;
      tmo       = tmo_q;
      cfg_bad   = cfg_bad_q;
      fatal     = fatal_q;
   end

endmodule
